// File: rtl/neuron_mac.sv
// neuron_mac: streams signed fixed-point (input, weight) pairs, accumulates the
// rescaled products with saturation and presents a bias-adjusted pre-activation sum.
module neuron_mac #(
    parameter int data_width = 16,
    parameter int frac_bits  = 12,
    parameter int num_inputs = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [data_width-1:0]   in_data,
    input  logic signed [data_width-1:0]   in_weight,
    input  logic signed [data_width-1:0]   bias,
    output logic signed [2*data_width-1:0] sum_out,
    output logic                           out_valid
);
    localparam int pw = 2 * data_width;
    localparam int cw = $clog2(num_inputs) + 1;

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_BIAS  = 2'd2;

    localparam logic signed [pw:0] sat_hi = {2'b00, {(pw-1){1'b1}}};
    localparam logic signed [pw:0] sat_lo = {2'b11, {(pw-1){1'b0}}};

    // Sums carry one guard bit so overflow is visible before clamping to pw bits.
    function automatic logic signed [pw-1:0] sat(input logic signed [pw:0] x);
        if (x > sat_hi) begin
            return sat_hi[pw-1:0];
        end else if (x < sat_lo) begin
            return sat_lo[pw-1:0];
        end
        return x[pw-1:0];
    endfunction

    logic [1:0]           state_q, state_d;
    logic [cw-1:0]        count_q, count_d;
    logic signed [pw-1:0] prod_q, prod_d;
    logic                 prod_vld_q, prod_vld_d;
    logic signed [pw-1:0] acc_q, acc_d;
    logic signed [pw-1:0] sum_q, sum_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic signed [pw-1:0] prod_shift;
    logic signed [pw:0]   acc_plus_prod;
    logic signed [pw:0]   acc_plus_bias;

    assign in_ready      = (state_q == ST_ACC);
    assign accept        = in_valid && in_ready;
    assign prod_shift    = prod_q >>> frac_bits;
    assign acc_plus_prod = {acc_q[pw-1], acc_q} + {prod_shift[pw-1], prod_shift};
    assign acc_plus_bias = {acc_q[pw-1], acc_q} + {{(data_width+1){bias[data_width-1]}}, bias};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        prod_d      = prod_q;
        prod_vld_d  = accept;
        acc_d       = acc_q;
        sum_d       = sum_q;
        out_valid_d = 1'b0;

        if (accept) begin
            prod_d = pw'(in_data) * pw'(in_weight);
        end
        if (prod_vld_q) begin
            acc_d = sat(acc_plus_prod);
        end

        // The product of the last beat lands in acc during FLUSH, so BIAS sees the full frame.
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (count_q == cw'(num_inputs - 1)) begin
                        count_d = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        count_d = count_q + cw'(1);
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_BIAS;
            end
            ST_BIAS: begin
                sum_d       = sat(acc_plus_bias);
                out_valid_d = 1'b1;
                acc_d       = '0;
                state_d     = ST_ACC;
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            count_q     <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum_out   = sum_q;
    assign out_valid = out_valid_q;

endmodule
